// File: rtl/ad9911_pkg.sv
// Shared constants and types for the AD9911 frequency loader: register addresses,
// serial frame lengths, the controller state set and the instruction-byte helper.
package ad9911_pkg;

    localparam int unsigned WORD_W = 40;

    localparam logic [4:0] ADDR_CSR  = 5'h00;
    localparam logic [4:0] ADDR_FR1  = 5'h01;
    localparam logic [4:0] ADDR_CTW0 = 5'h04;

    localparam logic [5:0] CSR_BITS = 6'd16;
    localparam logic [5:0] FR1_BITS = 6'd32;
    localparam logic [5:0] FTW_BITS = 6'd40;

    typedef enum logic [3:0] {
        S_RST,
        S_SETTLE,
        S_CSR,
        S_FR1,
        S_INIT_IOUP,
        S_IDLE,
        S_FTW,
        S_IOUP,
        S_DONE
    } state_t;

    // Serial-port instruction byte for a write: R/W = 0, two don't-care zeros, address.
    function automatic logic [7:0] instr_write(input logic [4:0] addr);
        return {1'b0, 2'b00, addr};
    endfunction

endpackage

// File: rtl/ad9911_spi_shifter.sv
// Single-bit SDIO serialiser for the AD9911: shifts a left-justified word MSB first,
// SCLK at half the system clock with a full clock of setup and hold around each rise.
module ad9911_spi_shifter
    import ad9911_pkg::*;
(
    input  logic              CLOCK_10M,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    input  logic [5:0]        bits,
    output logic              DDS_CS_N,
    output logic              DDS_SCLK,
    output logic              DDS_SDIO,
    output logic              done
);

    logic              active;
    logic [6:0]        phase;
    logic [6:0]        last_phase;
    logic [WORD_W-1:0] sreg;

    // Even phases present a new bit with SCLK low, odd phases raise SCLK; the phase
    // after the last bit releases chip select.
    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            active     <= 1'b0;
            phase      <= '0;
            last_phase <= '0;
            sreg       <= '0;
            DDS_CS_N   <= 1'b1;
            DDS_SCLK   <= 1'b0;
            DDS_SDIO   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !active) begin
                active     <= 1'b1;
                phase      <= '0;
                last_phase <= {bits, 1'b0};
                sreg       <= word;
                DDS_CS_N   <= 1'b0;
                DDS_SCLK   <= 1'b0;
            end else if (active) begin
                phase <= phase + 7'd1;
                if (phase == last_phase) begin
                    active   <= 1'b0;
                    DDS_CS_N <= 1'b1;
                    DDS_SCLK <= 1'b0;
                    DDS_SDIO <= 1'b0;
                    done     <= 1'b1;
                end else if (!phase[0]) begin
                    DDS_SDIO <= sreg[WORD_W-1];
                    sreg     <= {sreg[WORD_W-2:0], 1'b0};
                    DDS_SCLK <= 1'b0;
                end else begin
                    DDS_SCLK <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ad9911_freq_loader.sv
// AD9911 init and frequency-update responder for the transceiver sequencer.
// Optional build macro AD9911_HW_RESET_EN enables the MASTER_RESET pulse after reset.
module ad9911_freq_loader
    import ad9911_pkg::*;
#(
    parameter int unsigned PLL_MULT      = 20,
    parameter logic [3:0]  CH_MASK       = 4'b0011,
    parameter int unsigned RST_CYCLES    = 20,
    parameter int unsigned SETTLE_CYCLES = 100,
    parameter int unsigned IOUP_CYCLES   = 2
) (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic [31:0] FREQW,
    input  logic        UPDATE,
    output logic        UPDATED,
    output logic        INITIED,
    output logic        DDS_MASTER_RESET,
    output logic        DDS_CS_N,
    output logic        DDS_SCLK,
    output logic        DDS_SDIO,
    output logic        DDS_IO_UPDATE
);

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);
    localparam logic [15:0] IOUP_LAST   = 16'(IOUP_CYCLES - 1);
    localparam logic [4:0]  PLL_FIELD   = 5'(PLL_MULT);

    localparam logic [WORD_W-1:0] CSR_WORD =
        {instr_write(ADDR_CSR), CH_MASK, 4'b0000, 24'h000000};
    localparam logic [WORD_W-1:0] FR1_WORD =
        {instr_write(ADDR_FR1), 1'b1, PLL_FIELD, 2'b00, 16'h0000, 8'h00};

`ifdef AD9911_HW_RESET_EN
    localparam state_t RESET_STATE = S_RST;
`else
    localparam state_t RESET_STATE = S_SETTLE;
`endif

    state_t            state;
    state_t            state_next;
    logic [15:0]       cnt;
    logic              cnt_clr;
    logic              pending;
    logic              accept;
    logic              spi_start;
    logic [WORD_W-1:0] spi_word;
    logic [5:0]        spi_bits;
    logic              spi_done;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        accept     = 1'b0;
        spi_start  = 1'b0;
        spi_word   = '0;
        spi_bits   = '0;
        case (state)
            S_RST: begin
                if (cnt == RST_LAST) begin
                    state_next = S_SETTLE;
                    cnt_clr    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    spi_start  = 1'b1;
                    spi_word   = CSR_WORD;
                    spi_bits   = CSR_BITS;
                    state_next = S_CSR;
                end
            end
            S_CSR: begin
                if (spi_done) begin
                    spi_start  = 1'b1;
                    spi_word   = FR1_WORD;
                    spi_bits   = FR1_BITS;
                    state_next = S_FR1;
                end
            end
            S_FR1: begin
                if (spi_done) begin
                    state_next = S_INIT_IOUP;
                    cnt_clr    = 1'b1;
                end
            end
            S_INIT_IOUP: begin
                if (cnt == IOUP_LAST) begin
                    state_next = S_IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            S_IDLE: begin
                // The shifter's load of FREQW is the capture of the tuning word.
                if (UPDATE || pending) begin
                    accept     = 1'b1;
                    spi_start  = 1'b1;
                    spi_word   = {instr_write(ADDR_CTW0), FREQW};
                    spi_bits   = FTW_BITS;
                    state_next = S_FTW;
                end
            end
            S_FTW: begin
                if (spi_done) begin
                    state_next = S_IOUP;
                    cnt_clr    = 1'b1;
                end
            end
            S_IOUP: begin
                if (cnt == IOUP_LAST) begin
                    state_next = S_DONE;
                    cnt_clr    = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                cnt_clr    = 1'b1;
            end
            default: begin
                state_next = RESET_STATE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // Strobes are registered from the next state so they align with state entry.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= RESET_STATE;
            cnt           <= '0;
            pending       <= 1'b0;
            UPDATED       <= 1'b0;
            INITIED       <= 1'b0;
            DDS_IO_UPDATE <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_clr ? '0 : cnt + 16'd1;
            UPDATED       <= (state_next == S_DONE);
            DDS_IO_UPDATE <= (state_next == S_IOUP) || (state_next == S_INIT_IOUP);
            if (accept) begin
                pending <= 1'b0;
            end else if (UPDATE && (state != S_IDLE)) begin
                pending <= 1'b1;
            end
            if ((state == S_INIT_IOUP) && (state_next == S_IDLE)) begin
                INITIED <= 1'b1;
            end
        end
    end

`ifdef AD9911_HW_RESET_EN
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            DDS_MASTER_RESET <= 1'b0;
        end else begin
            DDS_MASTER_RESET <= (state_next == S_RST);
        end
    end
`else
    assign DDS_MASTER_RESET = 1'b0;
`endif

    ad9911_spi_shifter u_spi (
        .CLOCK_10M (CLOCK_10M),
        .RESET_N   (RESET_N),
        .start     (spi_start),
        .word      (spi_word),
        .bits      (spi_bits),
        .DDS_CS_N  (DDS_CS_N),
        .DDS_SCLK  (DDS_SCLK),
        .DDS_SDIO  (DDS_SDIO),
        .done      (spi_done)
    );

endmodule

// File: doc/ad9911_freq_loader.md
# ad9911_freq_loader

Responder side of the frequency-update handshake used by the signal transceiver sequencer. After reset it initialises the AD9911 over its serial port and raises `INITIED`. It then serves each `UPDATE` request by writing the requested 32-bit `FREQW` tuning word into CTW0, strobing IO_UPDATE, and pulsing `UPDATED`. It sits between the sequencer and the AD9911 pins, clocked on the 10 MHz system clock.

## Interface
Parameters:
- `PLL_MULT`, 20: REFCLK multiplier, written to FR1[6:2]; legal range 4..20.
- `CH_MASK`, 4'b0011: AD9911 channel-enable bits written to CSR[7:4].
- `RST_CYCLES`, 20: master-reset pulse width, in clocks.
- `SETTLE_CYCLES`, 100: wait after reset before the first SPI access.
- `IOUP_CYCLES`, 2: IO_UPDATE pulse width, in clocks (≥1).

Ports:
- `CLOCK_10M` in 1: sole clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `FREQW` in 32: frequency tuning word, sampled at request acceptance.
- `UPDATE` in 1: request; one-cycle pulse or level.
- `UPDATED` out 1: one-cycle completion pulse.
- `INITIED` out 1: level, high once initialisation completes.
- `DDS_MASTER_RESET` out 1: AD9911 MASTER_RESET pin.
- `DDS_CS_N` out 1: serial chip select.
- `DDS_SCLK` out 1: serial clock, idles low.
- `DDS_SDIO` out 1: serial data, MSB first, single-bit SDIO mode.
- `DDS_IO_UPDATE` out 1: register transfer strobe.

## Operation
- Reset values:
  - `UPDATED`, `INITIED`, `DDS_SCLK`, `DDS_SDIO` and `DDS_IO_UPDATE` = 0.
  - `DDS_CS_N` = 1.
  - `DDS_MASTER_RESET` = 0.
  - Pending flag = 0.
  - State = S_RST.
- State sequence: S_RST → S_SETTLE → S_CSR → S_FR1 → S_INIT_IOUP → S_IDLE ↔ (S_FTW → S_IOUP → S_DONE).
- S_RST: drives `DDS_MASTER_RESET` high for RST_CYCLES clocks.
- S_SETTLE: waits SETTLE_CYCLES clocks.
- S_CSR: writes instruction 0x00 followed by data {CH_MASK, 4'b0000}, 16 bits total.
- S_FR1: writes 0x01 followed by {1'b1, PLL_MULT[4:0], 2'b00, 16'h0000}, 32 bits total.
- S_INIT_IOUP: IO_UPDATE pulse. On exit `INITIED` goes high and stays high until reset.
- S_IDLE: if a request is present, captures `FREQW` and enters S_FTW.
  - A request is `UPDATE` high this cycle, or the pending flag set.
  - Capturing clears the pending flag.
- S_FTW: writes 0x04 followed by the captured FTW, 40 bits total.
- S_IOUP: IO_UPDATE pulse.
- S_DONE: `UPDATED` = 1 for exactly one cycle, then returns to S_IDLE.
- The instruction byte is always {1'b0 (write), 2'b00, addr[4:0]}.
- `UPDATE` high in any state other than S_IDLE sets the pending flag. This includes the whole init phase. Multiple such requests coalesce into one.
- A pending request is served with `FREQW` as sampled in the S_IDLE cycle that accepts it, not at the time of the original pulse.
- `RESET_N` asserted mid-transfer: all outputs return to their reset values asynchronously, `DDS_CS_N` rises immediately, and the init sequence reruns in full.

## Timing
- SPI frame of B bits, starting at edge t:
  - `DDS_CS_N` falls after edge t.
  - Bit i (i = 0..B−1, MSB first): `DDS_SDIO` changes after edge t+1+2i with `DDS_SCLK` low; `DDS_SCLK` is high after edge t+2+2i.
  - `DDS_CS_N` rises after edge t+2B+1, with `DDS_SCLK` low.
  - This gives SCLK = 5 MHz and one clock of setup/hold around each SCLK rise.
- FTW update, request accepted at edge k:
  - `DDS_CS_N` is low during k+1..k+81.
  - `DDS_IO_UPDATE` is high after edges k+82 .. k+81+IOUP_CYCLES.
  - `UPDATED` is high for the single cycle after edge k+82+IOUP_CYCLES. With defaults this is edge k+84.
- Back-to-back requests: the next request is accepted no earlier than one cycle after the `UPDATED` cycle.
- `UPDATED` is never high while `UPDATE` is being accepted. Consequently a requester that pulses `UPDATE` and then waits for `UPDATED` high cannot deadlock.

## Configuration
- Macro: `AD9911_HW_RESET_EN`.
- Defined: S_RST drives the `DDS_MASTER_RESET` pulse as described in Operation.
- Undefined:
  - S_RST is skipped; reset enters S_SETTLE directly.
  - `DDS_MASTER_RESET` is tied to 0.
  - All other behaviour is unchanged.

## Structure
- Package `ad9911_pkg` holds:
  - Register address constants: ADDR_CSR = 0x00, ADDR_FR1 = 0x01, ADDR_CTW0 = 0x04.
  - The state enumeration.
  - The frame-length constants 16, 32 and 40.
- Sub-module `ad9911_spi_shifter`:
  - Inputs: start pulse, 40-bit left-justified word, bit count.
  - Outputs: `DDS_CS_N`, `DDS_SCLK`, `DDS_SDIO`, one-cycle done pulse.
  - Owns the bit counter and the SCLK phase.
- The top-level FSM owns the reset/settle/IO_UPDATE counters, the pending flag and the handshake.

## Test plan
- Reset release with defaults:
  - `DDS_MASTER_RESET` high for 20 cycles.
  - CSR frame reads 0x00 0x30.
  - FR1 frame reads 0x01 0xD0 0x00 0x00.
  - IO_UPDATE pulse, then `INITIED` = 1.
- `FREQW` = 0x1234_5678 with a 1-cycle `UPDATE` pulse in idle:
  - A 40-bit frame decodes to 0x04 12 34 56 78.
  - `DDS_IO_UPDATE` high for 2 cycles.
  - `UPDATED` single pulse at k+84.
- `UPDATE` pulsed during init with `FREQW` = 0xA5A5_A5A5: exactly one FTW frame carrying 0xA5A5A5A5 follows `INITIED` rising.
- Two `UPDATE` pulses during one active write (`FREQW` changed to 0x0000_0001): one extra frame carrying 0x00000001 and two `UPDATED` pulses in total.
- `RESET_N` low at bit 20 of an FTW frame:
  - `DDS_CS_N` = 1 and `INITIED` = 0 immediately.
  - The full init sequence repeats after release.
- Build without `AD9911_HW_RESET_EN`: `DDS_MASTER_RESET` stays 0, and the CSR frame starts SETTLE_CYCLES+1 cycles after reset release.
